// File: rtl/commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// commit_trace_buffer
//
// Synthesizable commit-trace capture for the RISC-V core. Sits beside the core
// top level and records one entry per retired instruction. Every commit is
// counted; only commits whose index lies inside [win_start, win_end] are pushed
// into a DEPTH-entry first-word-fall-through FIFO that a consumer drains over a
// valid/ready port. In wrap mode a full FIFO overwrites its oldest record,
// otherwise new records are dropped. Either loss sets the sticky overflow flag.
//
// Ports
//   clk, reset      core clock, synchronous active-high reset
//   commit_*        retirement stream: valid, pc, instr, rd, we, wdata
//   win_start/end   inclusive commit-index window that gets captured
//   wrap_mode       0 = drop when full, 1 = overwrite oldest when full
//   clear           flush FIFO and overflow (commit counter is kept)
//   trace_valid     FIFO non-empty
//   trace_ready     consumer accepts the head record
//   trace_data      head record {pc, instr, rd, we, wdata}, MSB first
//   fill_level      records held, 0..DEPTH
//   instr_count     commits seen since reset (saturating)
//   overflow        sticky: a record was dropped or overwritten
//   window_done     instr_count has moved past win_end
// -----------------------------------------------------------------------------
module commit_trace_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 32,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     commit_valid,
  input  logic [XLEN-1:0]          commit_pc,
  input  logic [31:0]              commit_instr,
  input  logic [4:0]               commit_rd,
  input  logic                     commit_we,
  input  logic [XLEN-1:0]          commit_wdata,
  input  logic [CNT_W-1:0]         win_start,
  input  logic [CNT_W-1:0]         win_end,
  input  logic                     wrap_mode,
  input  logic                     clear,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [2*XLEN+37:0]       trace_data,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [CNT_W-1:0]         instr_count,
  output logic                     overflow,
  output logic                     window_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int RW = 2*XLEN + 38;

  localparam logic [AW-1:0]    PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [FW-1:0]    FILL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [FW-1:0]    FILL_FULL = FW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Trace storage; never reset, contents are only observable once written.
  logic [RW-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]    fill_q,   fill_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             ovf_q,    ovf_d;
  logic             mem_we;

  logic [RW-1:0]    rec;
  logic             in_win;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  assign rec = {commit_pc, commit_instr, commit_rd, commit_we, commit_wdata};

  // The commit index is the pre-increment count. An inverted window
  // (start > end) can never satisfy both bounds, so it captures nothing.
  assign in_win = (cnt_q >= win_start) && (cnt_q <= win_end);
  assign push   = commit_valid && in_win;

  // Full/empty come from the registered fill level only.
  assign full   = (fill_q == FILL_FULL);
  assign empty  = (fill_q == '0);
  assign pop    = !empty && trace_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    mem_we   = 1'b0;

    // Counter keeps running through clear; it only saturates.
    if (commit_valid && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push && !full) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
          fill_d = fill_q + FILL_ONE;
        end
      end else if (push && full) begin
        if (pop || wrap_mode) begin
          // Full FIFO: the write lands in the slot being vacated this cycle
          // (by the consumer, or by discarding the oldest in wrap mode).
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (!pop) begin
          ovf_d = 1'b1;
        end
      end else if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        fill_d   = fill_q - FILL_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[wr_ptr_q] <= rec;
    end
  end

  // First-word-fall-through head.
  assign trace_data  = mem[rd_ptr_q];
  assign trace_valid = !empty;
  assign fill_level  = fill_q;
  assign instr_count = cnt_q;
  assign overflow    = ovf_q;
  assign window_done = (cnt_q > win_end);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_commit_trace_buffer
//
// Bench for commit_trace_buffer. A queue scoreboard holds the records the
// buffer should contain; every popped record is compared against its front.
// Whole scenarios are described in a table of {inputs, expected results},
// followed by hand-written sequences for full+pop, clear and mid-drain reset.
// -----------------------------------------------------------------------------
module tb_commit_trace_buffer;

  localparam int XLEN  = 64;
  localparam int DEPTH = 32;
  localparam int CNT_W = 32;
  localparam int RW    = 2*XLEN + 38;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              commit_valid;
  logic [XLEN-1:0]   commit_pc;
  logic [31:0]       commit_instr;
  logic [4:0]        commit_rd;
  logic              commit_we;
  logic [XLEN-1:0]   commit_wdata;
  logic [CNT_W-1:0]  win_start;
  logic [CNT_W-1:0]  win_end;
  logic              wrap_mode;
  logic              clear;
  logic              trace_valid;
  logic              trace_ready;
  logic [RW-1:0]     trace_data;
  logic [FW-1:0]     fill_level;
  logic [CNT_W-1:0]  instr_count;
  logic              overflow;
  logic              window_done;

  commit_trace_buffer #(
    .XLEN (XLEN),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .commit_valid(commit_valid),
    .commit_pc   (commit_pc),
    .commit_instr(commit_instr),
    .commit_rd   (commit_rd),
    .commit_we   (commit_we),
    .commit_wdata(commit_wdata),
    .win_start   (win_start),
    .win_end     (win_end),
    .wrap_mode   (wrap_mode),
    .clear       (clear),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_data  (trace_data),
    .fill_level  (fill_level),
    .instr_count (instr_count),
    .overflow    (overflow),
    .window_done (window_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [RW-1:0] sb[$];
  int            model_cnt;
  logic [RW-1:0] last_pop;

  typedef struct {
    int ws;
    int we;
    int n;
    bit wrap;
    int exp_fill;
    bit exp_ovf;
    int exp_head;
    bit exp_done;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [XLEN-1:0] pc_of(input int i);
    return 64'h0000_0000_8000_0000 + 64'(i) * 64'd4;
  endfunction

  function automatic logic [RW-1:0] make_rec(input int i);
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] wdata;
    instr = 32'h0000_0013 ^ (32'(i) << 7);
    rd    = 5'(i);
    we    = i[0];
    wdata = {32'hC0DE_0000 ^ 32'(i), 32'(i * 3 + 1)};
    return {pc_of(i), instr, rd, we, wdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    commit_valid = 1'b0;
    trace_ready  = 1'b0;
    clear        = 1'b0;
    tick();
    reset = 1'b0;
    sb.delete();
    model_cnt = 0;
  endtask

  // One clock cycle: drive a commit (record derived from the model's commit
  // index), optional ready/clear, update the scoreboard, then clock.
  task automatic cycle(input logic cv, input logic rdy, input logic clr);
    logic [RW-1:0] rec;
    int            sz;
    bit            do_pop;
    bit            in_win;
    rec = make_rec(model_cnt);
    {commit_pc, commit_instr, commit_rd, commit_we, commit_wdata} = rec;
    commit_valid = cv;
    trace_ready  = rdy;
    clear        = clr;
    sz = sb.size();
    chk("trace_valid", 256'(trace_valid), 256'(sz != 0));
    do_pop = (sz != 0) && rdy;
    if (do_pop) begin
      chk("pop_data", 256'(trace_data), 256'(sb[0]));
    end
    if (clr) begin
      sb.delete();
    end else begin
      if (do_pop) begin
        last_pop = sb.pop_front();
      end
      in_win = cv && (model_cnt >= int'(win_start)) && (model_cnt <= int'(win_end));
      if (in_win) begin
        if (sz < DEPTH || do_pop) begin
          sb.push_back(rec);
        end else if (wrap_mode) begin
          void'(sb.pop_front());
          sb.push_back(rec);
        end
      end
    end
    if (cv) model_cnt++;
    tick();
    commit_valid = 1'b0;
    trace_ready  = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic drain(output int drained);
    int guard;
    drained = 0;
    guard   = 0;
    while (sb.size() != 0 && guard < DEPTH + 4) begin
      cycle(1'b0, 1'b1, 1'b0);
      drained++;
      guard++;
    end
    chk("drain_bound", 256'(sb.size()), 256'(0));
  endtask

  initial begin
    int drained;

    vecs[0] = '{ws: 30, we: 40, n: 64, wrap: 1'b0, exp_fill: 11, exp_ovf: 1'b0, exp_head: 30, exp_done: 1'b1};
    vecs[1] = '{ws: 0,  we: 99, n: 40, wrap: 1'b0, exp_fill: 32, exp_ovf: 1'b1, exp_head: 0,  exp_done: 1'b0};
    vecs[2] = '{ws: 0,  we: 99, n: 40, wrap: 1'b1, exp_fill: 32, exp_ovf: 1'b1, exp_head: 8,  exp_done: 1'b0};
    vecs[3] = '{ws: 10, we: 5,  n: 20, wrap: 1'b0, exp_fill: 0,  exp_ovf: 1'b0, exp_head: 0,  exp_done: 1'b1};
    vecs[4] = '{ws: 0,  we: 0,  n: 1,  wrap: 1'b0, exp_fill: 1,  exp_ovf: 1'b0, exp_head: 0,  exp_done: 1'b1};
    vecs[5] = '{ws: 5,  we: 36, n: 37, wrap: 1'b0, exp_fill: 32, exp_ovf: 1'b0, exp_head: 5,  exp_done: 1'b1};

    reset        = 1'b1;
    commit_valid = 1'b0;
    {commit_pc, commit_instr, commit_rd, commit_we, commit_wdata} = '0;
    win_start    = '0;
    win_end      = '0;
    wrap_mode    = 1'b0;
    clear        = 1'b0;
    trace_ready  = 1'b0;
    model_cnt    = 0;
    last_pop     = '0;

    // Reset state
    do_reset();
    chk("rst_valid", 256'(trace_valid), 256'(0));
    chk("rst_fill",  256'(fill_level),  256'(0));
    chk("rst_count", 256'(instr_count), 256'(0));
    chk("rst_ovf",   256'(overflow),    256'(0));
    chk("rst_done",  256'(window_done), 256'(0));
    $display("reset: valid=%0d fill=%0d count=%0d", trace_valid, fill_level, instr_count);

    // Table-driven scenarios
    for (int v = 0; v < 6; v++) begin
      win_start = CNT_W'(vecs[v].ws);
      win_end   = CNT_W'(vecs[v].we);
      wrap_mode = vecs[v].wrap;
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) cycle(1'b1, 1'b0, 1'b0);
      chk("vec_fill",  256'(fill_level),  256'(vecs[v].exp_fill));
      chk("vec_ovf",   256'(overflow),    256'(vecs[v].exp_ovf));
      chk("vec_count", 256'(instr_count), 256'(vecs[v].n));
      chk("vec_done",  256'(window_done), 256'(vecs[v].exp_done));
      chk("vec_valid", 256'(trace_valid), 256'(vecs[v].exp_fill != 0));
      if (vecs[v].exp_fill != 0) begin
        chk("vec_head_pc", 256'(trace_data[RW-1 -: XLEN]), 256'(pc_of(vecs[v].exp_head)));
      end
      drain(drained);
      chk("vec_drained",    256'(drained),    256'(vecs[v].exp_fill));
      chk("vec_after_fill", 256'(fill_level), 256'(0));
      $display("vec %0d: win=[%0d,%0d] wrap=%0d n=%0d drained=%0d ovf=%0d",
               v, vecs[v].ws, vecs[v].we, vecs[v].wrap, vecs[v].n, drained, overflow);
    end

    // Full FIFO, commit with ready=1 in the same cycle
    win_start = 0;
    win_end   = 99;
    wrap_mode = 1'b0;
    do_reset();
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("fullpop_pre_fill", 256'(fill_level), 256'(32));
    cycle(1'b1, 1'b1, 1'b0);
    chk("fullpop_fill",  256'(fill_level),  256'(32));
    chk("fullpop_ovf",   256'(overflow),    256'(0));
    chk("fullpop_count", 256'(instr_count), 256'(33));
    chk("fullpop_head",  256'(trace_data[RW-1 -: XLEN]), 256'(pc_of(1)));
    drain(drained);
    chk("fullpop_tail", 256'(last_pop[RW-1 -: XLEN]), 256'(pc_of(32)));
    $display("full+pop: drained=%0d tail_pc=%0h", drained, last_pop[RW-1 -: XLEN]);

    // clear together with a commit at idx 5
    win_start = 0;
    win_end   = 9;
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("clear_pre_fill", 256'(fill_level), 256'(5));
    cycle(1'b1, 1'b0, 1'b1);
    chk("clear_fill",  256'(fill_level),  256'(0));
    chk("clear_ovf",   256'(overflow),    256'(0));
    chk("clear_count", 256'(instr_count), 256'(6));
    chk("clear_valid", 256'(trace_valid), 256'(0));
    cycle(1'b1, 1'b0, 1'b0);
    chk("clear_next_fill", 256'(fill_level), 256'(1));
    chk("clear_next_head", 256'(trace_data[RW-1 -: XLEN]), 256'(pc_of(6)));
    $display("clear: fill=%0d count=%0d", fill_level, instr_count);

    // Reset mid-drain with fill=7 and overflow set
    win_start = 0;
    win_end   = 99;
    wrap_mode = 1'b0;
    do_reset();
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) cycle(1'b0, 1'b1, 1'b0);
    chk("middrain_fill", 256'(fill_level), 256'(7));
    chk("middrain_ovf",  256'(overflow),   256'(1));
    reset       = 1'b1;
    trace_ready = 1'b1;
    tick();
    reset       = 1'b0;
    trace_ready = 1'b0;
    sb.delete();
    model_cnt = 0;
    chk("rstdrain_valid", 256'(trace_valid), 256'(0));
    chk("rstdrain_fill",  256'(fill_level),  256'(0));
    chk("rstdrain_count", 256'(instr_count), 256'(0));
    chk("rstdrain_ovf",   256'(overflow),    256'(0));
    $display("reset mid-drain: valid=%0d fill=%0d count=%0d ovf=%0d",
             trace_valid, fill_level, instr_count, overflow);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
